// File: rtl/i2c_master_sequencer_pkg.sv
// Shared definitions for the I2C transaction sequencer: FSM state encoding
// and the command codes understood by the byte-level engine.
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ADDR  = 3'd2,
    S_WDATA = 3'd3,
    S_RDATA = 3'd4,
    S_STOP  = 3'd5,
    S_FIN   = 3'd6
  } state_e;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b11;

endpackage

// File: rtl/i2c_master_sequencer_if.sv
// Requester-side and engine-side signals of the sequencer bundled together;
// master is the sequencer view, slave is the view of requesters plus engine.
interface i2c_master_sequencer_if #(
  parameter int NREQ  = 4,
  parameter int LEN_W = 4
);
  logic [NREQ-1:0]       req;
  logic [7*NREQ-1:0]     req_addr;
  logic [NREQ-1:0]       req_rw;
  logic [LEN_W*NREQ-1:0] req_len;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  err;
  logic [7:0]            tx_data;
  logic                  tx_pop;
  logic [7:0]            rd_data;
  logic                  rd_valid;
  logic [1:0]            cmd;
  logic                  cmd_last;
  logic [7:0]            cmd_byte;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  eng_done;
  logic                  eng_nack;
  logic [7:0]            eng_rxbyte;

  modport master (
    input  req, req_addr, req_rw, req_len, tx_data,
           cmd_ready, eng_done, eng_nack, eng_rxbyte,
    output gnt, done, err, tx_pop, rd_data, rd_valid,
           cmd, cmd_last, cmd_byte, cmd_valid
  );

  modport slave (
    output req, req_addr, req_rw, req_len, tx_data,
           cmd_ready, eng_done, eng_nack, eng_rxbyte,
    input  gnt, done, err, tx_pop, rd_data, rd_valid,
           cmd, cmd_last, cmd_byte, cmd_valid
  );
endinterface

// File: rtl/i2c_master_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer,
// wrapping; the pointer register itself lives in the sequencer.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o,
  output logic            valid_o
);

  always_comb begin
    int j;
    logic found;
    j       = 0;
    found   = 1'b0;
    grant_o = '0;
    idx_o   = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr_i) + i) % NREQ;
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/i2c_master_sequencer.sv
// Shares one byte-level I2C engine among NREQ requesters: round-robin grant,
// then START, address byte, data bytes and STOP through a valid/ready handshake.
module i2c_master_sequencer
  import i2c_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int LEN_W = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  i2c_master_sequencer_if.master bus
);

  localparam int IW = $clog2(NREQ);

  state_e             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [6:0]         addr_q, addr_d;
  logic               rw_q, rw_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               errf_q, errf_d;
  logic               wait_q, wait_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;

  logic [NREQ-1:0]    arbGnt;
  logic [IW-1:0]      arbIdx;
  logic               arbValid;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .grant_o (arbGnt),
    .idx_o   (arbIdx),
    .valid_o (arbValid)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      gnt_q    <= '0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      cnt_q    <= '0;
      errf_q   <= 1'b0;
      wait_q   <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      cnt_q    <= cnt_d;
      errf_q   <= errf_d;
      wait_q   <= wait_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // wait_q splits every command state into "offering cmd" and "awaiting eng_done"
  always_comb begin
    int sel;
    sel      = int'(arbIdx);
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    cnt_d    = cnt_q;
    errf_d   = errf_q;
    wait_d   = wait_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arbValid) begin
          state_d = S_START;
          gnt_d   = arbGnt;
          idx_d   = arbIdx;
          addr_d  = bus.req_addr[7*sel +: 7];
          rw_d    = bus.req_rw[sel];
          cnt_d   = bus.req_len[LEN_W*sel +: LEN_W];
          wait_d  = 1'b0;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        errf_d  = 1'b0;
        ptr_d   = (idx_q == IW'(NREQ-1)) ? '0 : idx_q + 1'b1;
      end
      default: begin
        if (!wait_q) begin
          if (bus.cmd_ready) wait_d = 1'b1;
        end else if (bus.eng_done) begin
          wait_d = 1'b0;
          case (state_q)
            S_START: state_d = S_ADDR;
            S_ADDR: begin
              if (bus.eng_nack) begin
                errf_d  = 1'b1;
                state_d = S_STOP;
              end else if (cnt_q == '0) begin
                state_d = S_STOP;
              end else begin
                state_d = rw_q ? S_RDATA : S_WDATA;
              end
            end
            S_WDATA: begin
              cnt_d = cnt_q - 1'b1;
              if (bus.eng_nack) begin
                errf_d  = 1'b1;
                state_d = S_STOP;
              end else if (cnt_q == LEN_W'(1)) begin
                state_d = S_STOP;
              end
            end
            S_RDATA: begin
              cnt_d    = cnt_q - 1'b1;
              rdata_d  = bus.eng_rxbyte;
              rvalid_d = 1'b1;
              if (cnt_q == LEN_W'(1)) state_d = S_STOP;
            end
            S_STOP:  state_d = S_FIN;
            default: state_d = state_q;
          endcase
        end
      end
    endcase
  end

  // tx_pop is combinational so the requester's next byte is ready when WDATA re-offers
  always_comb begin
    bus.cmd       = CMD_START;
    bus.cmd_byte  = '0;
    bus.cmd_last  = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.tx_pop    = 1'b0;
    bus.done      = '0;
    bus.err       = 1'b0;
    case (state_q)
      S_START: bus.cmd_valid = !wait_q;
      S_ADDR: begin
        bus.cmd       = CMD_WRITE;
        bus.cmd_byte  = {addr_q, rw_q};
        bus.cmd_valid = !wait_q;
      end
      S_WDATA: begin
        bus.cmd       = CMD_WRITE;
        bus.cmd_byte  = bus.tx_data;
        bus.cmd_valid = !wait_q;
        bus.tx_pop    = wait_q && bus.eng_done;
      end
      S_RDATA: begin
        bus.cmd       = CMD_READ;
        bus.cmd_last  = (cnt_q == LEN_W'(1));
        bus.cmd_valid = !wait_q;
      end
      S_STOP: begin
        bus.cmd       = CMD_STOP;
        bus.cmd_valid = !wait_q;
      end
      S_FIN: begin
        bus.done = gnt_q;
        bus.err  = errf_q;
      end
      default: bus.cmd_valid = 1'b0;
    endcase
  end

  assign bus.gnt      = gnt_q;
  assign bus.rd_data  = rdata_q;
  assign bus.rd_valid = rvalid_q;

endmodule

// File: tb/tb_i2c_master_sequencer.sv
// Directed bench for the I2C sequencer: the bench plays requesters and a
// hand-stepped engine, checking each command against hand-computed values.
module tb_i2c_master_sequencer;

  localparam logic [1:0] C_START = 2'b00;
  localparam logic [1:0] C_WRITE = 2'b01;
  localparam logic [1:0] C_READ  = 2'b10;
  localparam logic [1:0] C_STOP  = 2'b11;

  logic CLK;
  logic RST;
  int   nAssert = 0;
  int   nFail   = 0;
  int   popCnt  = 0;
  int   rdCnt   = 0;
  int   doneCnt = 0;
  int   gntViol = 0;
  logic [7:0] rdBytes [16];

  i2c_master_sequencer_if #(.NREQ(4), .LEN_W(4)) bus ();

  i2c_master_sequencer #(.NREQ(4), .LEN_W(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // pulse and grant observer, sampled late in the low phase of the clock
  always begin
    @(negedge CLK);
    #4;
    if (RST === 1'b1) begin
      if (bus.tx_pop === 1'b1) popCnt++;
      if (bus.rd_valid === 1'b1) begin
        if (rdCnt < 16) rdBytes[rdCnt] = bus.rd_data;
        rdCnt++;
      end
      if (bus.done !== 4'b0000) doneCnt++;
      if (!$onehot0(bus.gnt)) gntViol++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [6:0] addr, input logic rw, input logic [3:0] len);
    bus.req_addr[7*idx +: 7] = addr;
    bus.req_rw[idx]          = rw;
    bus.req_len[4*idx +: 4]  = len;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".gnt"},       bus.gnt,       4'b0000);
    checkOutput({tag, ".done"},      bus.done,      4'b0000);
    checkOutput({tag, ".err"},       bus.err,       1'b0);
    checkOutput({tag, ".tx_pop"},    bus.tx_pop,    1'b0);
    checkOutput({tag, ".rd_valid"},  bus.rd_valid,  1'b0);
    checkOutput({tag, ".rd_data"},   bus.rd_data,   8'h00);
    checkOutput({tag, ".cmd_valid"}, bus.cmd_valid, 1'b0);
    checkOutput({tag, ".cmd_last"},  bus.cmd_last,  1'b0);
    checkOutput({tag, ".cmd"},       bus.cmd,       2'b00);
    checkOutput({tag, ".cmd_byte"},  bus.cmd_byte,  8'h00);
  endtask

  // wait for a command offer, check it, then hold off cmd_ready for `delay` cycles
  task automatic waitCmd(input string tag, input logic [1:0] eCmd, input logic [7:0] eByte,
                         input logic eLast, input int delay);
    int n;
    logic [1:0] c0;
    logic [7:0] b0;
    n = 0;
    do begin
      @(negedge CLK);
      #2;
      n++;
    end while (bus.cmd_valid !== 1'b1 && n < 60);
    checkOutput({tag, ".valid"}, bus.cmd_valid, 1'b1);
    checkOutput({tag, ".cmd"}, bus.cmd, eCmd);
    if (eCmd == C_WRITE) checkOutput({tag, ".byte"}, bus.cmd_byte, eByte);
    if (eCmd == C_READ)  checkOutput({tag, ".last"}, bus.cmd_last, eLast);
    c0 = bus.cmd;
    b0 = bus.cmd_byte;
    for (int k = 0; k < delay; k++) begin
      @(negedge CLK);
      #2;
      checkOutput({tag, ".holdValid"}, bus.cmd_valid, 1'b1);
      checkOutput({tag, ".holdCmd"}, {bus.cmd, bus.cmd_byte}, {c0, b0});
    end
  endtask

  task automatic respond(input string tag, input logic nack, input logic [7:0] rx);
    bus.cmd_ready = 1'b1;
    @(negedge CLK);
    #2;
    bus.cmd_ready = 1'b0;
    checkOutput({tag, ".dropValid"}, bus.cmd_valid, 1'b0);
    bus.eng_done   = 1'b1;
    bus.eng_nack   = nack;
    bus.eng_rxbyte = rx;
    @(negedge CLK);
    #2;
    bus.eng_done   = 1'b0;
    bus.eng_nack   = 1'b0;
    bus.eng_rxbyte = 8'h00;
  endtask

  task automatic serve(input string tag, input logic [1:0] eCmd, input logic [7:0] eByte,
                       input logic eLast, input int delay, input logic nack, input logic [7:0] rx);
    waitCmd(tag, eCmd, eByte, eLast, delay);
    respond(tag, nack, rx);
  endtask

  task automatic finishTxn(input string tag, input logic [3:0] expDone, input logic expErr);
    checkOutput({tag, ".done"}, bus.done, expDone);
    checkOutput({tag, ".err"},  bus.err,  expErr);
    checkOutput({tag, ".gntFin"}, bus.gnt, expDone);
    @(negedge CLK);
    #2;
    checkOutput({tag, ".doneDrop"}, bus.done, 4'b0000);
    checkOutput({tag, ".gntDrop"},  bus.gnt,  4'b0000);
  endtask

  initial begin
    RST            = 1'b0;
    bus.req        = '0;
    bus.req_addr   = '0;
    bus.req_rw     = '0;
    bus.req_len    = '0;
    bus.tx_data    = 8'h00;
    bus.cmd_ready  = 1'b0;
    bus.eng_done   = 1'b0;
    bus.eng_nack   = 1'b0;
    bus.eng_rxbyte = 8'h00;
    repeat (3) @(negedge CLK);
    #2;
    checkIdle("reset");
    RST = 1'b1;

    $display("[TB] write, requester 0");
    applyStimulus(0, 7'h50, 1'b0, 4'd2);
    bus.tx_data = 8'hA5;
    bus.req     = 4'b0001;
    @(negedge CLK);
    #2;
    checkOutput("wr.latGnt", bus.gnt, 4'b0001);
    checkOutput("wr.latValid", bus.cmd_valid, 1'b1);
    checkOutput("wr.latCmd", bus.cmd, C_START);
    serve("wr.start", C_START, 8'h00, 1'b0, 0, 1'b0, 8'h00);
    serve("wr.addr",  C_WRITE, 8'hA0, 1'b0, 0, 1'b0, 8'h00);
    serve("wr.d0",    C_WRITE, 8'hA5, 1'b0, 0, 1'b0, 8'h00);
    bus.tx_data = 8'h3C;
    serve("wr.d1",    C_WRITE, 8'h3C, 1'b0, 0, 1'b0, 8'h00);
    serve("wr.stop",  C_STOP,  8'h00, 1'b0, 0, 1'b0, 8'h00);
    finishTxn("wr", 4'b0001, 1'b0);
    bus.req = 4'b0000;
    checkOutput("wr.pops", popCnt, 2);

    $display("[TB] read, requester 1");
    applyStimulus(1, 7'h21, 1'b1, 4'd3);
    bus.req = 4'b0010;
    serve("rd.start", C_START, 8'h00, 1'b0, 0, 1'b0, 8'h00);
    serve("rd.addr",  C_WRITE, 8'h43, 1'b0, 0, 1'b0, 8'h00);
    serve("rd.b0",    C_READ,  8'h00, 1'b0, 0, 1'b0, 8'h11);
    serve("rd.b1",    C_READ,  8'h00, 1'b0, 0, 1'b0, 8'h22);
    serve("rd.b2",    C_READ,  8'h00, 1'b1, 0, 1'b0, 8'h33);
    serve("rd.stop",  C_STOP,  8'h00, 1'b0, 0, 1'b0, 8'h00);
    finishTxn("rd", 4'b0010, 1'b0);
    bus.req = 4'b0000;
    checkOutput("rd.count", rdCnt, 3);
    checkOutput("rd.byte0", rdBytes[0], 8'h11);
    checkOutput("rd.byte1", rdBytes[1], 8'h22);
    checkOutput("rd.byte2", rdBytes[2], 8'h33);
    checkOutput("rd.pops", popCnt, 2);

    $display("[TB] address nack, requester 2");
    applyStimulus(2, 7'h7F, 1'b0, 4'd4);
    bus.req = 4'b0100;
    serve("nk.start", C_START, 8'h00, 1'b0, 0, 1'b0, 8'h00);
    serve("nk.addr",  C_WRITE, 8'hFE, 1'b0, 0, 1'b1, 8'h00);
    serve("nk.stop",  C_STOP,  8'h00, 1'b0, 0, 1'b0, 8'h00);
    finishTxn("nk", 4'b0100, 1'b1);
    bus.req = 4'b0000;
    checkOutput("nk.pops", popCnt, 2);

    $display("[TB] round-robin with all requesters active");
    RST = 1'b0;
    @(negedge CLK);
    #2;
    RST = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(i, 7'h10 + 7'(i), 1'b0, 4'd0);
    bus.req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      logic [3:0] oh;
      logic [7:0] ab;
      oh = 4'b0001 << (t % 4);
      ab = 8'h20 + 8'((t % 4) * 2);
      waitCmd("rr.start", C_START, 8'h00, 1'b0, 0);
      checkOutput("rr.gnt", bus.gnt, oh);
      respond("rr.start", 1'b0, 8'h00);
      serve("rr.addr", C_WRITE, ab, 1'b0, 0, 1'b0, 8'h00);
      serve("rr.stop", C_STOP, 8'h00, 1'b0, 0, 1'b0, 8'h00);
      finishTxn("rr", oh, 1'b0);
    end
    bus.req = 4'b0000;

    $display("[TB] probe with slow engine, requester 1");
    applyStimulus(1, 7'h2A, 1'b1, 4'd0);
    bus.req = 4'b0010;
    @(negedge CLK);
    #2;
    bus.eng_done = 1'b1;
    @(negedge CLK);
    #2;
    bus.eng_done = 1'b0;
    serve("pr.start", C_START, 8'h00, 1'b0, 5, 1'b0, 8'h00);
    serve("pr.addr",  C_WRITE, 8'h55, 1'b0, 5, 1'b0, 8'h00);
    serve("pr.stop",  C_STOP,  8'h00, 1'b0, 5, 1'b0, 8'h00);
    finishTxn("pr", 4'b0010, 1'b0);
    bus.req = 4'b0000;
    checkOutput("pr.noReads", rdCnt, 3);

    $display("[TB] reset during write data, requester 2");
    applyStimulus(2, 7'h33, 1'b0, 4'd3);
    bus.tx_data = 8'h99;
    bus.req     = 4'b0100;
    serve("rs.start", C_START, 8'h00, 1'b0, 0, 1'b0, 8'h00);
    serve("rs.addr",  C_WRITE, 8'h66, 1'b0, 0, 1'b0, 8'h00);
    waitCmd("rs.d0", C_WRITE, 8'h99, 1'b0, 0);
    RST     = 1'b0;
    bus.req = 4'b0000;
    @(negedge CLK);
    #2;
    RST = 1'b1;
    checkIdle("rs.after");
    applyStimulus(0, 7'h44, 1'b0, 4'd0);
    bus.req = 4'b0101;
    @(negedge CLK);
    #2;
    checkOutput("rs.regrant", bus.gnt, 4'b0001);
    checkOutput("rs.regrantValid", bus.cmd_valid, 1'b1);
    bus.req = 4'b0000;

    checkOutput("total.done", doneCnt, 9);
    checkOutput("total.onehot", gntViol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
